// File: rtl/msk_sbox_layer_sched.sv
// ---------------------------------------------------------------------------
// msk_sbox_layer_sched
//
// Masked Ascon S-box layer scheduler. Holds the 320-bit d-share masked state
// and streams PAR bit-columns per cycle into an external array of PAR
// pipelined masked S-boxes of fixed latency SBOX_LAT. Results come back
// SBOX_LAT cycles later and are written back in place. Fresh randomness is
// taken through a valid/ready handshake and forwarded alongside each column.
//
// Optional build macro: MSK_SBOX_SCHED_RC_EN
//   When defined, share 0 of x2 bits 0..7 is XORed with the round constant
//   captured at start while those columns are issued. The stored state
//   itself is never modified by the constant.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   load, state_in      capture masked state (IDLE only)
//                       bit b of x_i, share s at index (i*64+b)*D+s
//   rc_in               round constant (optional feature only)
//   start               begin one S-box layer pass (IDLE, load low)
//   busy, done          pass in progress / one-cycle end-of-pass pulse
//   state_out           the state register
//   rnd_in, rnd_valid   fresh randomness and its valid
//   rnd_ready           randomness consumed this cycle
//   sb_in, sb_rnd       column and randomness to the S-box array
//                       lane k at [k*5*D +: 5*D], x_i at [k*5*D+i*D +: D]
//   sb_out              S-box array outputs, same lane layout as sb_in
// ---------------------------------------------------------------------------
module msk_sbox_layer_sched #(
    parameter int D        = 2,
    parameter int PAR      = 4,
    parameter int SBOX_LAT = 2,
    parameter int NRND     = D * (D - 1) / 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [320*D-1:0]      state_in,
    input  logic [7:0]            rc_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [320*D-1:0]      state_out,
    input  logic [PAR*5*NRND-1:0] rnd_in,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    output logic [PAR*5*D-1:0]    sb_in,
    output logic [PAR*5*NRND-1:0] sb_rnd,
    input  logic [PAR*5*D-1:0]    sb_out
);

    localparam int NCOL = 64 / PAR;
    localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int SW   = 320 * D;
    localparam int LW   = 5 * D;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                   fsm_r;
    logic [1:0]                   fsm_nx_s;
    logic [CW-1:0]                col_r;
    logic [CW-1:0]                col_nx_s;
    logic [SW-1:0]                state_r;
    logic [SW-1:0]                wb_state_s;
    logic [SBOX_LAT-1:0]          tag_v_r;
    logic [SBOX_LAT-1:0][CW-1:0]  tag_c_r;
    logic                         issue_s;
    logic                         pend_s;
    logic                         wb_s;
    logic [CW-1:0]                wb_col_s;
    logic [PAR*5*D-1:0]           col_data_s;

    // A column goes out only in ISSUE and only when randomness is available.
    assign issue_s   = (fsm_r == ST_ISSUE) && rnd_valid;
    assign wb_s      = tag_v_r[SBOX_LAT-1];
    assign wb_col_s  = tag_c_r[SBOX_LAT-1];

    assign busy      = (fsm_r == ST_ISSUE) || (fsm_r == ST_DRAIN);
    assign done      = (fsm_r == ST_DONE);
    assign rnd_ready = issue_s;
    assign state_out = state_r;
    // Bubbles drive zeros so no earlier column or randomness is replayed.
    assign sb_in     = issue_s ? col_data_s : '0;
    assign sb_rnd    = issue_s ? rnd_in : '0;

`ifdef MSK_SBOX_SCHED_RC_EN
    logic [7:0] rc_r;

    // Round constant captured when a pass is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_r <= 8'd0;
        end else if ((fsm_r == ST_IDLE) && start && !load) begin
            rc_r <= rc_in;
        end else begin
            rc_r <= rc_r;
        end
    end
`else
    logic rc_unused_s;
    assign rc_unused_s = ^rc_in;
`endif

    // Gather column col_r: lane k carries bit col_r*PAR+k of every word/share.
    always_comb begin
        col_data_s = '0;
        for (int c = 0; c < NCOL; c++) begin
            for (int k = 0; k < PAR; k++) begin
                for (int i = 0; i < 5; i++) begin
                    for (int s = 0; s < D; s++) begin
                        col_data_s[k*LW + i*D + s] = col_data_s[k*LW + i*D + s]
                            | (state_r[(i*64 + c*PAR + k)*D + s] & (col_r == CW'(c)));
                    end
                end
            end
        end
`ifdef MSK_SBOX_SCHED_RC_EN
        // Constant only touches share 0 of x2, so shares stay separated.
        for (int b = 0; b < 8; b++) begin
            col_data_s[(b % PAR)*LW + 2*D] = col_data_s[(b % PAR)*LW + 2*D]
                ^ (rc_r[b] & (col_r == CW'(b / PAR)));
        end
`endif
    end

    // Scatter the returning column back into its original bit positions.
    always_comb begin
        wb_state_s = state_r;
        for (int b = 0; b < 64; b++) begin
            for (int i = 0; i < 5; i++) begin
                for (int s = 0; s < D; s++) begin
                    if (wb_s && (wb_col_s == CW'(b / PAR))) begin
                        wb_state_s[(i*64 + b)*D + s] = sb_out[(b % PAR)*LW + i*D + s];
                    end else begin
                        wb_state_s[(i*64 + b)*D + s] = state_r[(i*64 + b)*D + s];
                    end
                end
            end
        end
    end

    // Valid tags still inside the array other than the one retiring now.
    always_comb begin
        pend_s = 1'b0;
        for (int t = 0; t < SBOX_LAT - 1; t++) begin
            pend_s = pend_s | tag_v_r[t];
        end
    end

    // Next-state and column counter logic.
    always_comb begin
        fsm_nx_s = fsm_r;
        col_nx_s = col_r;
        case (fsm_r)
            ST_IDLE: begin
                if (start && !load) begin
                    fsm_nx_s = ST_ISSUE;
                    col_nx_s = '0;
                end else begin
                    fsm_nx_s = ST_IDLE;
                    col_nx_s = col_r;
                end
            end
            ST_ISSUE: begin
                if (issue_s && (col_r == CW'(NCOL - 1))) begin
                    fsm_nx_s = ST_DRAIN;
                    col_nx_s = col_r;
                end else if (issue_s) begin
                    fsm_nx_s = ST_ISSUE;
                    col_nx_s = col_r + CW'(1);
                end else begin
                    fsm_nx_s = ST_ISSUE;
                    col_nx_s = col_r;
                end
            end
            ST_DRAIN: begin
                // The tag in the last slot retires on this same edge.
                if (!pend_s) begin
                    fsm_nx_s = ST_DONE;
                end else begin
                    fsm_nx_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                fsm_nx_s = ST_IDLE;
            end
            default: begin
                fsm_nx_s = ST_IDLE;
                col_nx_s = '0;
            end
        endcase
    end

    // FSM state and column counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r <= ST_IDLE;
            col_r <= '0;
        end else begin
            fsm_r <= fsm_nx_s;
            col_r <= col_nx_s;
        end
    end

    // Tag pipeline mirrors the array latency; it advances every cycle
    // because the array itself has no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_r <= '0;
            tag_c_r <= '0;
        end else begin
            tag_v_r[0] <= issue_s;
            tag_c_r[0] <= col_r;
            for (int t = 1; t < SBOX_LAT; t++) begin
                tag_v_r[t] <= tag_v_r[t-1];
                tag_c_r[t] <= tag_c_r[t-1];
            end
        end
    end

    // State register: load in IDLE, otherwise in-place column writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= '0;
        end else if ((fsm_r == ST_IDLE) && load) begin
            state_r <= state_in;
        end else begin
            state_r <= wb_state_s;
        end
    end

endmodule

// File: doc/msk_sbox_layer_sched.md
Name: msk_sbox_layer_sched

Overview:
- Masked Ascon S-box layer scheduler: holds the 320-bit d-share masked state and streams PAR bit-columns per cycle into an external array of PAR pipelined masked S-boxes (5*d-bit slices, fixed latency SBOX_LAT).
- Writes the returned columns back in place and hands out per-column fresh randomness through a valid/ready handshake.
- Sits directly upstream of the S-box array and between the round datapath's state load and the linear diffusion stage.

Parameters:
- d, 2, number of shares (>=2).
- PAR, 4, S-boxes per cycle; must divide 64.
- SBOX_LAT, 2, S-box array latency in cycles (randomness consumed at latency 0).
- NRND, d*(d-1)/2, random bits per AND gadget; 5 gadgets per S-box.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  capture state_in into the state register.
- state_in  in  320*d  masked state; bit b of word x_i, share s, at index (i*64+b)*d+s.
- rc_in  in  8  round constant (used only with the optional feature).
- start  in  1  begin one S-box layer pass.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.
- state_out  out  320*d  state register, same layout as state_in.
- rnd_in  in  PAR*5*NRND  fresh randomness.
- rnd_valid  in  1  rnd_in valid.
- rnd_ready  out  1  randomness consumed this cycle.
- sb_in  out  PAR*5*d  to S-box array; lane k slice [k*5*d +: 5*d], word x_i at [k*5*d+i*d +: d].
- sb_rnd  out  PAR*5*NRND  randomness to array, aligned with sb_in.
- sb_out  in  PAR*5*d  S-box array outputs, same slice layout.

Behaviour:
- Reset (async, rst_n=0):
  - state register cleared to 0; FSM to IDLE.
  - column counter, valid/column-tag pipeline and rc register cleared.
  - busy, done, rnd_ready all 0; sb_in and sb_rnd driven 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - load=1 captures state_in.
  - start=1 with load=0 goes to ISSUE, clears column counter to 0, captures rc_in.
  - start=1 with load=1 in the same cycle: load wins and start is ignored.
- ISSUE:
  - busy=1; rnd_ready=rnd_valid.
  - Issue cycle (rnd_valid=1):
    - sb_in carries column c: lane k gets bits b=c*PAR+k of x0..x4, all shares.
    - sb_rnd=rnd_in.
    - Tag (valid=1, c) enters a SBOX_LAT-deep shift register; c increments.
  - Stall cycle (rnd_valid=0):
    - sb_in and sb_rnd driven 0; bubble tag (valid=0) enters the shift register.
    - c holds. Tags must track every cycle because the array has no enable.
  - After column 64/PAR-1 is issued, go to DRAIN.
- Writeback: when the shift-register output tag is valid, sb_out is written into the state at the tag's column, in every state.
- DRAIN: busy=1, rnd_ready=0; when the shift register holds no valid tags and the last writeback is done, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- load and start while busy are ignored; load has no effect outside IDLE.
- Latency with no stalls: done rises in cycle 64/PAR+SBOX_LAT+1 after the start edge (19 for defaults). Each stall cycle adds exactly 1.
- state_out always reflects the register. It is a consistent post-S-box state only in DONE/IDLE.
- Masking:
  - Shares are never combined.
  - Each randomness word is issued once only.
  - Bubble cycles drive sb_in to 0 and do not replay previous data.

Optional Feature:
- MSK_SBOX_SCHED_RC_EN defined:
  - During issue of columns holding x2 bits 0..7, share 0 of each such x2 bit is XORed with the captured rc bit before driving sb_in.
  - The stored state is not modified.
- Undefined: rc_in is ignored, no rc register is built, and sb_in carries the state unmodified.

Test Plan:
- d=2, PAR=4, all-zero state, rnd_valid=1, start → done at cycle 19; recombined x2=0xFFFFFFFFFFFFFFFF and x0,x1,x3,x4=0. Check against an unmasked Ascon S-box model.
- Random masked state, random rnd, rnd_valid low for 5 scattered cycles → done at cycle 24; recombined result matches the model; no repeated rnd word on sb_rnd.
- rst_n pulsed low at issue column 7 → busy, done, rnd_ready and state_out all 0 immediately. A subsequent load+start with zero state completes normally.
- load with a new state and a second start mid-pass → ignored; result equals the original input's S-box output. load and start in the same IDLE cycle → state loaded, no pass starts.
- With MSK_SBOX_SCHED_RC_EN defined and rc_in=0x4B, zero state → result equals the model applied to x2 low byte 0x4B. Without the macro → result identical to rc_in=0.
- PAR=64, SBOX_LAT=2 → single issue cycle; done at cycle 4.
